// File: rtl/skinny_inv_sbox8_hpc2_1_pkg.sv
// Shared types and wiring tables for the two-share HPC2 inverse SKINNY-128 S-box.
// Wire index space for the network: 0..7 are o bits, 8..15 are b bits.
package skinny_inv_sbox8_hpc2_1_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned LAT_DEFAULT = 8;
   localparam int unsigned LAT_MIN     = 5;
   localparam int unsigned LAT_MAX     = 15;
   localparam int unsigned N_GADGETS   = 8;

   // Fresh-randomness slice of gadget g: r[lo] masks cross terms, r[hi] refreshes y.
   function automatic int unsigned gadget_r_lo(input int unsigned g);
      return 2 * g;
   endfunction

   function automatic int unsigned gadget_r_hi(input int unsigned g);
      return 2 * g + 1;
   endfunction

   function automatic int unsigned gadget_x(input int unsigned g);
      case (g)
         0: return 3;
         1: return 7;
         2: return 2;
         3: return 6;
         4: return 5;
         5: return 11;
         6: return 10;
         7: return 15;
         default: return 0;
      endcase
   endfunction

   function automatic int unsigned gadget_y(input int unsigned g);
      case (g)
         0: return 1;
         1: return 6;
         2: return 7;
         3: return 5;
         4: return 11;
         5: return 10;
         6: return 9;
         7: return 14;
         default: return 0;
      endcase
   endfunction

   // z operands are always o bits, so the index is into o directly.
   function automatic int unsigned gadget_z(input int unsigned g);
      case (g)
         0: return 0;
         1: return 4;
         2: return 1;
         3: return 7;
         4: return 3;
         5: return 5;
         6: return 2;
         7: return 6;
         default: return 0;
      endcase
   endfunction

   // Output bit of b produced by gadget g.
   function automatic int unsigned gadget_out(input int unsigned g);
      case (g)
         0: return 2;
         1: return 3;
         2: return 7;
         3: return 5;
         4: return 1;
         5: return 0;
         6: return 6;
         7: return 4;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/hpc2_1_str_sbox8_cfn_fr.sv
// First-order HPC2 gadget computing NOR(x,y) ^ z on two shares; share 0 carries inversions.
// Cross terms are staged on negedge, products on posedge: one cycle from stable inputs.
module hpc2_1_str_sbox8_cfn_fr (
   input  logic       clk,
   input  logic       x1_i,
   input  logic       x0_i,
   input  logic       y1_i,
   input  logic       y0_i,
   input  logic       z1_i,
   input  logic       z0_i,
   input  logic [1:0] r_i,
   output logic       c1_o,
   output logic       c0_o
);

   logic a1, a0, b1, b0;
   logic rm_q, bx1_q, bx0_q;
   logic p1_q, p0_q, m1_q, m0_q, n1_q, n0_q;

   // NOR(x,y) = (~x)&(~y); y is refreshed with r[1] before any share mixing.
   assign a1 = x1_i;
   assign a0 = ~x0_i;
   assign b1 = y1_i ^ r_i[1];
   assign b0 = ~y0_i ^ r_i[1];

   always_ff @(negedge clk) begin
      rm_q  <= r_i[0];
      bx1_q <= b0 ^ r_i[0];
      bx0_q <= b1 ^ r_i[0];
   end

   always_ff @(posedge clk) begin
      p1_q <= a1 & b1;
      p0_q <= a0 & b0;
      m1_q <= ~a1 & rm_q;
      m0_q <= ~a0 & rm_q;
      n1_q <= a1 & bx1_q;
      n0_q <= a0 & bx0_q;
   end

   assign c1_o = p1_q ^ m1_q ^ n1_q ^ z1_i;
   assign c0_o = p0_q ^ m0_q ^ n0_q ^ z0_i;

endmodule

// File: rtl/skinny_inv_sbox8_hpc2_1_core.sv
// Masked inverse S-box network: eight NOR-XOR gadgets in four dependency levels.
module skinny_inv_sbox8_hpc2_1_core
   import skinny_inv_sbox8_hpc2_1_pkg::*;
(
   input  logic        clk,
   input  logic [7:0]  o1_i,
   input  logic [7:0]  o0_i,
   input  logic [15:0] r_i,
   output logic [7:0]  b1_o,
   output logic [7:0]  b0_o
);

   logic [7:0]  b1, b0;
   logic [15:0] w1, w0;

   // x/y operands may be o or b bits; z is only ever an o bit, so no combinational loop.
   assign w1 = {b1, o1_i};
   assign w0 = {b0, o0_i};

   generate
      for (genvar gi = 0; gi < N_GADGETS; gi++) begin : g_gadget
         localparam int unsigned XI = gadget_x(gi);
         localparam int unsigned YI = gadget_y(gi);
         localparam int unsigned ZI = gadget_z(gi);
         localparam int unsigned OI = gadget_out(gi);
         localparam int unsigned RL = gadget_r_lo(gi);
         localparam int unsigned RH = gadget_r_hi(gi);

         hpc2_1_str_sbox8_cfn_fr u_gadget (
            .clk  (clk),
            .x1_i (w1[XI]),
            .x0_i (w0[XI]),
            .y1_i (w1[YI]),
            .y0_i (w0[YI]),
            .z1_i (o1_i[ZI]),
            .z0_i (o0_i[ZI]),
            .r_i  ({r_i[RH], r_i[RL]}),
            .c1_o (b1[OI]),
            .c0_o (b0[OI])
         );
      end
   endgenerate

   assign b1_o = b1;
   assign b0_o = b0;

endmodule

// File: rtl/skinny_inv_sbox8_hpc2_1_seq.sv
// Handshaked wrapper: holds masked inputs and randomness stable while the network
// settles, then latches the output shares after a fixed latency.
module skinny_inv_sbox8_hpc2_1_seq
   import skinny_inv_sbox8_hpc2_1_pkg::*;
#(
   parameter int unsigned LAT = LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  si1,
   input  logic [7:0]  si0,
   input  logic [15:0] r,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  bo1,
   output logic [7:0]  bo0
);

   // Out-of-range LAT is pulled into the legal window rather than producing a bad result.
   localparam int unsigned LAT_EFF  = (LAT < LAT_MIN) ? LAT_MIN :
                                      (LAT > LAT_MAX) ? LAT_MAX : LAT;
   localparam logic [3:0]  CNT_LOAD = 4'(LAT_EFF - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  si1_q, si0_q;
   logic [15:0] r_q;
   logic [7:0]  bo1_q, bo0_q;
   logic [7:0]  net_b1, net_b0;
   logic        hold_en, capture_en;

   skinny_inv_sbox8_hpc2_1_core u_core (
      .clk  (clk),
      .o1_i (si1_q),
      .o0_i (si0_q),
      .r_i  (r_q),
      .b1_o (net_b1),
      .b0_o (net_b0)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_en    = 1'b0;
      capture_en = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_en = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               capture_en = 1'b1;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         si1_q   <= 8'h00;
         si0_q   <= 8'h00;
         r_q     <= 16'h0000;
         bo1_q   <= 8'h00;
         bo0_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hold_en) begin
            si1_q <= si1;
            si0_q <= si0;
            r_q   <= r;
         end
         if (capture_en) begin
            bo1_q <= net_b1;
            bo0_q <= net_b0;
         end
      end
   end

   assign bo1 = bo1_q;
   assign bo0 = bo0_q;

endmodule

// File: tb/tb_skinny_inv_sbox8_hpc2_1_seq.sv
// Directed bench: expected values come from a bit-sliced forward SKINNY-128 S-box model.
`timescale 1ns/1ps
module tb_skinny_inv_sbox8_hpc2_1_seq;

   localparam int unsigned LAT_A = 8;
   localparam int unsigned LAT_B = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  si1, si0, bo1, bo0;
   logic [15:0] r;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_si1, b_si0, b_bo1, b_bo0;
   logic [15:0] b_r;

   int pass_cnt = 0;
   int total    = 0;

   skinny_inv_sbox8_hpc2_1_seq #(.LAT(LAT_A)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .si1(si1), .si0(si0), .r(r), .out_valid(out_valid), .out_ready(out_ready),
      .bo1(bo1), .bo0(bo0)
   );

   skinny_inv_sbox8_hpc2_1_seq #(.LAT(LAT_B)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .si1(b_si1), .si0(b_si0), .r(b_r), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .bo1(b_bo1), .bo0(b_bo0)
   );

   // Forward SKINNY-128 S-box: four NOR-mix rounds with bit permutations, final swap.
   function automatic logic [7:0] sb_mix(input logic [7:0] x);
      logic [7:0] t;
      t = (x >> 1) | x;
      t = t >> 2;
      return x ^ (~t & 8'h11);
   endfunction

   function automatic logic [7:0] sb_perm(input logic [7:0] x);
      return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
             ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] v);
      logic [7:0] x;
      x = sb_mix(v);
      x = sb_mix(sb_perm(x));
      x = sb_mix(sb_perm(x));
      x = sb_mix(sb_perm(x));
      return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
   endfunction

   // Drive one request into dut (assumed idle); returns recombined result and edges to out_valid.
   task automatic do_op(input logic [7:0] s1, input logic [7:0] s0, input logic [15:0] rr,
                        output logic [7:0] res, output int lat);
      @(negedge clk);
      si1 = s1; si0 = s0; r = rr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      si1 = 8'($urandom); si0 = 8'($urandom); r = 16'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bo1 ^ bo0;
      $display("op si1=%02h si0=%02h r=%04h -> bo1=%02h bo0=%02h b=%02h lat=%0d",
               s1, s0, rr, bo1, bo0, res, lat);
   endtask

   task automatic finish_op();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; out_ready = 1'b1; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_low_valid: out_valid=%b expected 0", out_valid);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bo1 !== 8'h00 || bo0 !== 8'h00)
         $display("FAIL reset_state: in_ready=%b out_valid=%b bo1=%02h bo0=%02h expected 1 0 00 00",
                  in_ready, out_valid, bo1, bo0);
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL idle_out_ready: out_valid=%b expected 0", out_valid);
      else pass_cnt++;
      out_ready = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] res;
      logic [7:0] m;
      int lat;
      do_op(8'h65, 8'h00, 16'($urandom), res, lat);
      total++;
      if (res !== 8'h00 || lat != LAT_A)
         $display("FAIL basic_65: b=%02h lat=%0d expected 00 lat=%0d", res, lat, LAT_A);
      else pass_cnt++;
      finish_op();
      m = 8'h9E;
      do_op(8'h4C ^ m, m, 16'h1234, res, lat);
      total++;
      if (res !== 8'h01 || lat != LAT_A)
         $display("FAIL basic_4c: b=%02h lat=%0d expected 01 lat=%0d", res, lat, LAT_A);
      else pass_cnt++;
      finish_op();
   endtask

   task automatic test_ff();
      logic [7:0] res;
      logic [7:0] m;
      int lat;
      do_op(8'h3C, 8'hC3, 16'hA5C3, res, lat);
      total++;
      if (res !== 8'hFF || lat != LAT_A)
         $display("FAIL ff_fixed: b=%02h lat=%0d expected FF lat=%0d", res, lat, LAT_A);
      else pass_cnt++;
      finish_op();
      for (int i = 0; i < 100; i++) begin
         m = 8'($urandom);
         do_op(8'hFF ^ m, m, 16'($urandom), res, lat);
         total++;
         if (res !== 8'hFF || lat != LAT_A)
            $display("FAIL ff_random[%0d]: b=%02h lat=%0d expected FF lat=%0d", i, res, lat, LAT_A);
         else pass_cnt++;
         finish_op();
      end
   endtask

   task automatic test_all256();
      logic [7:0] res;
      logic [7:0] m;
      logic [7:0] o;
      int lat;
      for (int v = 0; v < 256; v++) begin
         o = sbox_fwd(8'(v));
         m = 8'($urandom);
         do_op(o ^ m, m, 16'($urandom), res, lat);
         total++;
         if (res !== 8'(v) || lat != LAT_A)
            $display("FAIL all256[%02h]: b=%02h lat=%0d expected %02h lat=%0d", v, res, lat, v, LAT_A);
         else pass_cnt++;
         finish_op();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] res;
      logic [7:0] m;
      logic [7:0] held1, held0;
      int lat;
      bit ok;
      m = 8'h37;
      do_op(sbox_fwd(8'h5A) ^ m, m, 16'hBEEF, res, lat);
      total++;
      if (res !== 8'h5A || lat != LAT_A)
         $display("FAIL bp_result: b=%02h lat=%0d expected 5A lat=%0d", res, lat, LAT_A);
      else pass_cnt++;
      held1 = bo1; held0 = bo0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1;
         si1 = 8'($urandom); si0 = 8'($urandom); r = 16'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || bo1 !== held1 || bo0 !== held0)
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b bo1=%02h bo0=%02h expected 1 0 %02h %02h",
                     i, out_valid, in_ready, bo1, bo0, held1, held0);
         else pass_cnt++;
      end
      // Handoff edge with in_valid also high: must not accept on the same edge.
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_handoff: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      else pass_cnt++;
      ok = 1'b1;
      for (int i = 0; i < int'(LAT_A) + 2; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL bp_no_phantom: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      logic [7:0] res;
      int lat;
      bit ok;
      do_op(8'h3C, 8'hC3, 16'h0F0F, res, lat);
      finish_op();
      total++;
      if ((bo1 | bo0) === 8'h00)
         $display("FAIL abort_pre: bo1=%02h bo0=%02h expected nonzero shares", bo1, bo0);
      else pass_cnt++;
      @(negedge clk);
      si1 = sbox_fwd(8'h01) ^ 8'h55; si0 = 8'h55; r = 16'h7777; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || bo1 !== 8'h00 || bo0 !== 8'h00)
         $display("FAIL abort_reset: out_valid=%b bo1=%02h bo0=%02h expected 0 00 00", out_valid, bo1, bo0);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL abort_idle: in_ready=%b expected 1", in_ready);
      else pass_cnt++;
      ok = 1'b1;
      for (int i = 0; i < int'(LAT_A) + 2; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      total++;
      if (!ok) $display("FAIL abort_discard: out_valid=%b expected 0", out_valid);
      else pass_cnt++;
      do_op(8'h65, 8'h00, 16'hC0DE, res, lat);
      total++;
      if (res !== 8'h00 || lat != LAT_A)
         $display("FAIL abort_next: b=%02h lat=%0d expected 00 lat=%0d", res, lat, LAT_A);
      else pass_cnt++;
      finish_op();
   endtask

   task automatic test_back_to_back();
      logic [7:0] items [6];
      logic [7:0] masks [6];
      int acc_c [6];
      logic [7:0] res;
      int k, done, c, prev_out;
      logic acc;
      items[0] = 8'h00; items[1] = 8'h01; items[2] = 8'hFF;
      items[3] = 8'h5A; items[4] = 8'hC3; items[5] = 8'h7E;
      for (int i = 0; i < 6; i++) begin
         masks[i] = 8'($urandom);
         acc_c[i] = 0;
      end
      k = 0; done = 0; c = 0; prev_out = 0;
      b_out_ready = 1'b1;
      while (done < 6 && c < 200) begin
         @(negedge clk);
         if (k < 6) begin
            b_in_valid = 1'b1;
            b_si1 = sbox_fwd(items[k]) ^ masks[k];
            b_si0 = masks[k];
            b_r   = 16'($urandom);
         end else begin
            b_in_valid = 1'b0;
         end
         acc = b_in_valid && b_in_ready;
         @(posedge clk); #1;
         c++;
         if (acc) begin
            acc_c[k] = c;
            k++;
         end
         if (b_out_valid) begin
            res = b_bo1 ^ b_bo0;
            $display("b2b item=%0d bo1=%02h bo0=%02h b=%02h cycle=%0d", done, b_bo1, b_bo0, res, c);
            total++;
            if (done >= k) begin
               $display("FAIL b2b_unexpected: out_valid=1 with %0d accepted, %0d returned", k, done);
            end else if (res !== items[done] || c - acc_c[done] != int'(LAT_B) ||
                         (done > 0 && c - prev_out != int'(LAT_B) + 2)) begin
               $display("FAIL b2b[%0d]: b=%02h lat=%0d gap=%0d expected %02h lat=%0d gap=%0d",
                        done, res, c - acc_c[done], c - prev_out, items[done], LAT_B, LAT_B + 2);
            end else begin
               pass_cnt++;
            end
            prev_out = c;
            done++;
         end
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b0;
      total++;
      if (done != 6) $display("FAIL b2b_timeout: results=%0d expected 6", done);
      else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; si1 = 8'h00; si0 = 8'h00; r = 16'h0000;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_si1 = 8'h00; b_si0 = 8'h00; b_r = 16'h0000;
      test_reset();
      test_basic();
      test_ff();
      test_all256();
      test_backpressure();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
